// File: rtl/flush_ctrl_pkg.sv
// Shared types and constants for the branch-mispredict recovery sequencer.
// The optional feature macro FLUSH_PERF_CNT_EN is consumed by flush_ctrl.sv.
package flush_ctrl_pkg;

    localparam int unsigned ROB_WIDTH = 4;
    localparam int unsigned ROB_NUM   = 1 << ROB_WIDTH;
    localparam int unsigned ROBID_W   = ROB_WIDTH + 1;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned PERF_W    = 32;

    typedef logic [ROBID_W-1:0] robid_t;

    typedef enum logic [1:0] {
        rob_idle     = 2'd0,
        rob_rollback = 2'd1,
        rob_walk     = 2'd2
    } rob_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ROLLBK = 2'd2,
        S_WALK   = 2'd3
    } flush_state_t;

    typedef struct packed {
        logic            valid;
        robid_t          robid;
        logic [XLEN-1:0] target;
    } flush_req_t;

    // Distance from the retire pointer; the wrap bit makes plain subtraction correct.
    function automatic robid_t rob_age(robid_t id, robid_t tail);
        return robid_t'(id - tail);
    endfunction

endpackage

// File: rtl/flush_ctrl_if.sv
// Bundle of mispredict request, ROB status and recovery control signals.
// master drives requests/ROB status; slave is the flush controller.
interface flush_ctrl_if;
    import flush_ctrl_pkg::*;

    logic                br0_req_valid;
    robid_t              br0_req_robid;
    logic [XLEN-1:0]     br0_req_target;
    logic                br1_req_valid;
    robid_t              br1_req_robid;
    logic [XLEN-1:0]     br1_req_target;
    robid_t              rob_tail;
    logic [1:0]          rob_state;

    logic                flush_valid;
    robid_t              flush_robid;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                fe_flush;
    logic                disp_stall;
    logic                busy;

    modport master (
        output br0_req_valid, br0_req_robid, br0_req_target,
        output br1_req_valid, br1_req_robid, br1_req_target,
        output rob_tail, rob_state,
        input  flush_valid, flush_robid, redirect_valid, redirect_pc,
        input  fe_flush, disp_stall, busy
    );

    modport slave (
        input  br0_req_valid, br0_req_robid, br0_req_target,
        input  br1_req_valid, br1_req_robid, br1_req_target,
        input  rob_tail, rob_state,
        output flush_valid, flush_robid, redirect_valid, redirect_pc,
        output fe_flush, disp_stall, busy
    );

endinterface

// File: rtl/flush_ctrl_rob_age_cmp.sv
// Combinational age compare: older_c is set when robid a is strictly older than b
// relative to the current retire pointer.
module rob_age_cmp
    import flush_ctrl_pkg::*;
(
    input  robid_t a_i,
    input  robid_t b_i,
    input  robid_t tail_i,
    output logic   older_c
);

    robid_t age_a;
    robid_t age_b;

    assign age_a   = rob_age(a_i, tail_i);
    assign age_b   = rob_age(b_i, tail_i);
    assign older_c = (age_a < age_b);

endmodule

// File: rtl/flush_ctrl.sv
// Mispredict recovery sequencer: picks the oldest branch mispredict, issues the ROB
// flush and fetch redirect, and stalls dispatch until the ROB rollback/walk ends.
// Optional perf counters are built when FLUSH_PERF_CNT_EN is defined.
module flush_ctrl
    import flush_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    flush_ctrl_if.slave       bus
`ifdef FLUSH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    flush_state_t    state_q, state_d;
    flush_req_t      br0_c, br1_c, win_c;
    logic            br1_older_c;
    logic            win_older_c;
    logic            accept_c;

    logic            flush_valid_q, flush_valid_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            fe_flush_q, fe_flush_d;
    logic            disp_stall_q, disp_stall_d;
    logic            busy_q, busy_d;
    robid_t          flush_robid_q, flush_robid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    assign br0_c = '{valid: bus.br0_req_valid, robid: bus.br0_req_robid,
                     target: bus.br0_req_target};
    assign br1_c = '{valid: bus.br1_req_valid, robid: bus.br1_req_robid,
                     target: bus.br1_req_target};

    rob_age_cmp u_sel_cmp (
        .a_i     (br1_c.robid),
        .b_i     (br0_c.robid),
        .tail_i  (bus.rob_tail),
        .older_c (br1_older_c)
    );

    // br1 wins only when strictly older, so equal ages fall to br0
    always_comb begin
        win_c = br0_c;
        if (br1_c.valid && (!br0_c.valid || br1_older_c)) begin
            win_c = br1_c;
        end
    end

    rob_age_cmp u_act_cmp (
        .a_i     (win_c.robid),
        .b_i     (flush_robid_q),
        .tail_i  (bus.rob_tail),
        .older_c (win_older_c)
    );

    // Mid-recovery only a strictly older branch may restart the flush
    assign accept_c = !reset && win_c.valid && ((state_q == S_IDLE) || win_older_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = accept_c ? S_ISSUE : S_ROLLBK;
            end
            S_ROLLBK: begin
                if (accept_c) begin
                    state_d = S_ISSUE;
                end else if ((bus.rob_state == rob_rollback) ||
                             (bus.rob_state == rob_walk)) begin
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (accept_c) begin
                    state_d = S_ISSUE;
                end else if (bus.rob_state == rob_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear one cycle after accept
    always_comb begin
        flush_valid_d    = 1'b0;
        redirect_valid_d = 1'b0;
        fe_flush_d       = 1'b0;
        disp_stall_d     = 1'b0;
        busy_d           = 1'b0;
        flush_robid_d    = flush_robid_q;
        redirect_pc_d    = redirect_pc_q;

        if (accept_c) begin
            flush_robid_d = win_c.robid;
            redirect_pc_d = win_c.target;
        end

        if (state_d == S_ISSUE) begin
            flush_valid_d    = 1'b1;
            redirect_valid_d = 1'b1;
            fe_flush_d       = 1'b1;
        end

        if (state_d != S_IDLE) begin
            disp_stall_d = 1'b1;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_valid_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            fe_flush_q       <= 1'b0;
            disp_stall_q     <= 1'b0;
            busy_q           <= 1'b0;
            flush_robid_q    <= '0;
            redirect_pc_q    <= '0;
        end else begin
            flush_valid_q    <= flush_valid_d;
            redirect_valid_q <= redirect_valid_d;
            fe_flush_q       <= fe_flush_d;
            disp_stall_q     <= disp_stall_d;
            busy_q           <= busy_d;
            flush_robid_q    <= flush_robid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.flush_valid    = flush_valid_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.fe_flush       = fe_flush_q;
    assign bus.disp_stall     = disp_stall_q;
    assign bus.busy           = busy_q;
    assign bus.flush_robid    = flush_robid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef FLUSH_PERF_CNT_EN
    logic [PERF_W-1:0] perf_flush_q;
    logic [PERF_W-1:0] perf_stall_q;

    // Saturating counters: every issue (including re-issue) and every stalled cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept_c && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
            if (disp_stall_q && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_flush_cnt = perf_flush_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_flush_ctrl.sv
// Self-checking bench for flush_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural recovery model.
module tb_flush_ctrl;
    import flush_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    flush_ctrl_if bus ();

`ifdef FLUSH_PERF_CNT_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    flush_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef FLUSH_PERF_CNT_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: recovering / flush-pulse / ROB-engaged flags
    bit          m_rec;
    bit          m_issue;
    bit          m_eng;
    logic [4:0]  m_robid;
    logic [31:0] m_pc;
    longint      m_fcnt;
    longint      m_scnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int age(input logic [4:0] id, input logic [4:0] tail);
        return (int'(id) - int'(tail) + 32) % 32;
    endfunction

    task automatic model_step();
        int   a0, a1, aw;
        bit   have, acc;
        logic [4:0]  w_id;
        logic [31:0] w_pc;
        if (reset) begin
            m_rec = 0; m_issue = 0; m_eng = 0;
            m_robid = '0; m_pc = '0; m_fcnt = 0; m_scnt = 0;
            return;
        end
        if (m_rec && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        a0 = age(bus.br0_req_robid, bus.rob_tail);
        a1 = age(bus.br1_req_robid, bus.rob_tail);
        have = bus.br0_req_valid || bus.br1_req_valid;
        if (bus.br1_req_valid && (!bus.br0_req_valid || a1 < a0)) begin
            w_id = bus.br1_req_robid; w_pc = bus.br1_req_target;
        end else begin
            w_id = bus.br0_req_robid; w_pc = bus.br0_req_target;
        end
        aw  = age(w_id, bus.rob_tail);
        acc = have && (!m_rec || aw < age(m_robid, bus.rob_tail));
        if (acc) begin
            m_robid = w_id; m_pc = w_pc;
            m_rec = 1; m_issue = 1; m_eng = 0;
            if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
        end else if (m_issue) begin
            m_issue = 0;
        end else if (m_rec && !m_eng) begin
            if (bus.rob_state == 2'd1 || bus.rob_state == 2'd2) m_eng = 1;
        end else if (m_rec && m_eng && bus.rob_state == 2'd0) begin
            m_rec = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("flush_valid",    32'(bus.flush_valid),    32'(m_issue));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_issue));
        chk("fe_flush",       32'(bus.fe_flush),       32'(m_issue));
        chk("disp_stall",     32'(bus.disp_stall),     32'(m_rec));
        chk("busy",           32'(bus.busy),           32'(m_rec));
        chk("flush_robid",    32'(bus.flush_robid),    32'(m_robid));
        chk("redirect_pc",    bus.redirect_pc,         m_pc);
`ifdef FLUSH_PERF_CNT_EN
        chk("perf_flush_cnt", perf_flush_cnt, 32'(m_fcnt));
        chk("perf_stall_cnt", perf_stall_cnt, 32'(m_scnt));
`endif
    endtask

    task automatic no_req();
        bus.br0_req_valid = 1'b0; bus.br0_req_robid = '0; bus.br0_req_target = '0;
        bus.br1_req_valid = 1'b0; bus.br1_req_robid = '0; bus.br1_req_target = '0;
    endtask

    task automatic req0(input logic [4:0] id, input logic [31:0] pc);
        bus.br0_req_valid = 1'b1; bus.br0_req_robid = id; bus.br0_req_target = pc;
    endtask

    task automatic req1(input logic [4:0] id, input logic [31:0] pc);
        bus.br1_req_valid = 1'b1; bus.br1_req_robid = id; bus.br1_req_target = pc;
    endtask

    initial begin
        reset = 1'b1;
        no_req();
        bus.rob_tail = '0;
        bus.rob_state = 2'd0;
        cycle(); cycle();
        chk("rst_flush_valid", 32'(bus.flush_valid), 32'd0);
        chk("rst_busy",        32'(bus.busy),        32'd0);
        chk("rst_redirect_pc", bus.redirect_pc,      32'd0);
        reset = 1'b0;

        // Single flush through rollback/walk/idle
        req0(5'd5, 32'h100);
        cycle();
        chk("single_flush_valid", 32'(bus.flush_valid), 32'd1);
        chk("single_robid",       32'(bus.flush_robid), 32'd5);
        chk("single_pc",          bus.redirect_pc,      32'h100);
        no_req();
        cycle();
        chk("single_pulse_end",   32'(bus.flush_valid), 32'd0);
        bus.rob_state = 2'd1; cycle();
        bus.rob_state = 2'd2; cycle();
        chk("single_stall_walk",  32'(bus.disp_stall),  32'd1);
        bus.rob_state = 2'd0; cycle();
        chk("single_stall_fall",  32'(bus.disp_stall),  32'd0);
        chk("single_robid_held",  32'(bus.flush_robid), 32'd5);

        // Dual request across the wrap: br1 (age 1) beats br0 (age 5)
        bus.rob_tail = 5'h1E;
        req0(5'h03, 32'h200); req1(5'h1F, 32'h300);
        cycle();
        chk("dual_robid", 32'(bus.flush_robid), 32'h1F);
        chk("dual_pc",    bus.redirect_pc,      32'h300);
        no_req();
        cycle();
        bus.rob_state = 2'd1; cycle();
        bus.rob_state = 2'd0; cycle();
        chk("dual_idle", 32'(bus.busy), 32'd0);

        // Older preempt / younger drop, also the perf scenario
        reset = 1'b1; cycle(); reset = 1'b0;
        bus.rob_tail = '0;
        req0(5'd8, 32'h400); cycle();
        no_req(); cycle();
        req0(5'd10, 32'h500); cycle();
        chk("drop_no_pulse", 32'(bus.flush_valid), 32'd0);
        chk("drop_robid",    32'(bus.flush_robid), 32'd8);
        no_req(); bus.rob_state = 2'd1; cycle();
        req1(5'd6, 32'h600); bus.rob_state = 2'd2; cycle();
        chk("preempt_flush",    32'(bus.flush_valid),    32'd1);
        chk("preempt_redirect", 32'(bus.redirect_valid), 32'd1);
        chk("preempt_robid",    32'(bus.flush_robid),    32'd6);
        chk("preempt_pc",       bus.redirect_pc,         32'h600);
        no_req(); cycle();
        cycle();
        bus.rob_state = 2'd0; cycle();
        chk("preempt_idle", 32'(bus.busy), 32'd0);
`ifdef FLUSH_PERF_CNT_EN
        chk("perf_flush_dir", perf_flush_cnt, 32'd2);
        chk("perf_stall_dir", perf_stall_cnt, 32'd7);
`endif

        // Equal age tie goes to br0; equal robid mid-recovery is dropped
        req0(5'd7, 32'hA); req1(5'd7, 32'hB); cycle();
        chk("tie_pc", bus.redirect_pc, 32'hA);
        no_req(); req1(5'd7, 32'hC); cycle();
        chk("equal_drop", 32'(bus.flush_valid), 32'd0);
        chk("equal_pc",   bus.redirect_pc,      32'hA);
        no_req(); bus.rob_state = 2'd1; cycle();
        bus.rob_state = 2'd0; cycle();

        // Wrap-boundary preempt: tail 0x1C, active 0x02 (age 6), new 0x1D (age 1)
        bus.rob_tail = 5'h1C;
        req0(5'h02, 32'h700); cycle();
        no_req(); cycle();
        req1(5'h1D, 32'h800); cycle();
        chk("wrap_preempt_robid", 32'(bus.flush_robid), 32'h1D);
        no_req(); bus.rob_state = 2'd1; cycle();

        // Reset mid-recovery with a pending request
        bus.rob_state = 2'd2; cycle();
        reset = 1'b1; req0(5'h1E, 32'h900); cycle();
        chk("rst_mid_busy",  32'(bus.busy),        32'd0);
        chk("rst_mid_stall", 32'(bus.disp_stall),  32'd0);
        chk("rst_mid_robid", 32'(bus.flush_robid), 32'd0);
        reset = 1'b0; no_req(); bus.rob_state = 2'd0; cycle();
        chk("rst_req_dropped", 32'(bus.flush_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) bus.rob_tail = ROBID_W'($urandom);
            bus.br0_req_valid  = ($urandom_range(0, 3) == 0);
            bus.br0_req_robid  = ROBID_W'($urandom);
            bus.br0_req_target = $urandom;
            bus.br1_req_valid  = ($urandom_range(0, 3) == 0);
            bus.br1_req_robid  = ($urandom_range(0, 7) == 0) ? bus.br0_req_robid
                                                             : ROBID_W'($urandom);
            bus.br1_req_target = $urandom;
            bus.rob_state      = 2'($urandom_range(0, 2));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
